// File: rtl/debounce_sync.sv
// Debounce conditioner: multi-stage synchronizer feeding a four-state
// stability FSM that produces a registered level plus rise/fall strobes.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_rise;
  logic                   w_fall;

  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
          w_fall      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they change in the
  // same cycle as the state register and stay glitch-free downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_WAIT_LOW);
      r_busy  <= (w_state_nxt == ST_WAIT_HIGH) || (w_state_nxt == ST_WAIT_LOW);
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  assign dout       = r_dout;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync with default parameters; expected
// {dout,rise,fall,busy} per edge are queued at drive time and checked after the edge.
module tb_debounce_sync;

  logic clk;
  logic rst;
  logic din;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic [3:0] v;
    int unsigned edge_no;
  } exp_t;

  exp_t sb[$];

  debounce_sync #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] pack(input logic d, input logic r, input logic f, input logic b);
    return {d, r, f, b};
  endfunction

  task automatic tick(input logic din_v, input logic rst_v);
    din = din_v;
    rst = rst_v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    logic [3:0] got;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back('{v: 4'b0000, edge_no: k});
      tick(1'b1, 1'b1);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{v: pack(k >= 10, k == 10, 1'b0, (k >= 3 && k <= 9)), edge_no: k});
      tick(1'b1, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  task automatic test_clean_fall;
    exp_t e;
    logic [3:0] got;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{v: pack(k < 10, 1'b0, k == 10, (k >= 3 && k <= 9)), edge_no: k});
      tick(1'b0, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL clean_fall edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  task automatic test_clean_rise;
    exp_t e;
    logic [3:0] got;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{v: pack(k >= 10, k == 10, 1'b0, (k >= 3 && k <= 9)), edge_no: k});
      tick(1'b1, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL clean_rise edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  // Fall flips on edge 10; the rise starts on edge 11 and flips 8 edges later.
  task automatic test_back_to_back;
    exp_t e;
    logic [3:0] got;
    logic d;
    for (int k = 1; k <= 20; k++) begin
      d = (k >= 9);
      sb.push_back('{v: pack((k < 10) || (k >= 18), k == 18, k == 10,
                             (k >= 3 && k <= 9) || (k >= 11 && k <= 17)), edge_no: k});
      tick(d, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL back_to_back edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  task automatic test_bounce;
    exp_t e;
    logic [3:0] got;
    for (int k = 1; k <= 14; k++) begin
      sb.push_back('{v: pack(1'b0, 1'b0, 1'b0, (k >= 3 && k <= 7)), edge_no: k});
      tick(k <= 5, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  // s drops on exactly the edge where the count would complete.
  task automatic test_boundary_glitch;
    exp_t e;
    logic [3:0] got;
    for (int k = 1; k <= 14; k++) begin
      sb.push_back('{v: pack(1'b0, 1'b0, 1'b0, (k >= 3 && k <= 9)), edge_no: k});
      tick(k <= 7, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL boundary_glitch edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  task automatic test_reset_mid_qual;
    exp_t e;
    logic [3:0] got;
    for (int k = 1; k <= 7; k++) begin
      sb.push_back('{v: pack(1'b0, 1'b0, 1'b0, k >= 3), edge_no: k});
      tick(1'b1, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL mid_qual_pre edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
    sb.push_back('{v: 4'b0000, edge_no: 8});
    tick(1'b1, 1'b1);
    e = sb.pop_front();
    got = pack(dout, rise_pulse, fall_pulse, busy);
    n_tests++;
    if (got !== e.v) begin
      n_fail++;
      $display("FAIL mid_qual_reset edge %0d: got %b required %b", e.edge_no, got, e.v);
    end
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{v: pack(k >= 10, k == 10, 1'b0, (k >= 3 && k <= 9)), edge_no: k});
      tick(1'b1, 1'b0);
      e = sb.pop_front();
      got = pack(dout, rise_pulse, fall_pulse, busy);
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL mid_qual_requal edge %0d: got %b required %b", e.edge_no, got, e.v);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    din     = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_fall();
    test_clean_rise();
    test_back_to_back();
    test_clean_fall();
    test_bounce();
    test_boundary_glitch();
    test_reset_mid_qual();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
